// File: rtl/crossing_request_unit.sv
`timescale 1ns/1ps
// crossing_request_unit: conditions the raw push-button and vehicle detector
// into walk/sensor requests, holding each one until the controller serves it.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no pedestrian request outstanding
//   PENDING | walk asserted to the controller, walk_wait counting
//   SERVING | walk lamp on; a new press arms a follow-up request (rearm)
module crossing_request_unit #(
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             button_raw,
  input  logic             car_raw,
  input  logic             walk_light,
  input  logic [1:0]       side_light,
  output logic             walk,
  output logic             sensor,
  output logic [CNT_W-1:0] walk_wait
);

  localparam int              DB_W    = $clog2(DEBOUNCE + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);
  localparam logic [1:0]      SIDE_GREEN = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SERVING = 2'd2
  } walk_state_t;

  // Bit 0 carries the push-button, bit 1 the vehicle detector.
  logic [1:0]            s1;
  logic [1:0]            s2;
  logic [1:0]            db;
  logic [1:0]            db_d;
  logic [1:0][DB_W-1:0]  db_cnt;

  logic                  press;
  logic                  arrival;

  walk_state_t           state;
  walk_state_t           state_next;
  logic [CNT_W-1:0]      wait_next;
  logic                  rearm;
  logic                  rearm_next;

  logic                  car_req;
  logic                  car_req_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1     <= '0;
      s2     <= '0;
      db     <= '0;
      db_d   <= '0;
      db_cnt <= '0;
    end else begin
      s1   <= {car_raw, button_raw};
      s2   <= s1;
      db_d <= db;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] != db[i]) begin
          // The DEBOUNCE-th consecutive differing sample flips the level.
          if (db_cnt[i] == DB_LAST) begin
            db[i]     <= ~db[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign press   = db[0] & ~db_d[0];
  assign arrival = db[1] & ~db_d[1];

  always_comb begin
    state_next = state;
    wait_next  = walk_wait;
    rearm_next = rearm;
    case (state)
      IDLE: begin
        if (press) begin
          state_next = PENDING;
          wait_next  = '0;
        end
      end
      PENDING: begin
        if (walk_wait != '1) begin
          wait_next = walk_wait + 1'b1;
        end
        if (walk_light) begin
          state_next = SERVING;
        end
      end
      SERVING: begin
        rearm_next = rearm | press;
        if (!walk_light) begin
          rearm_next = 1'b0;
          if (rearm || press) begin
            state_next = PENDING;
            wait_next  = '0;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Clear has priority over a simultaneous arrival.
  assign car_req_next = (car_req | arrival) & (side_light != SIDE_GREEN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      walk_wait <= '0;
      rearm     <= 1'b0;
      walk      <= 1'b0;
      car_req   <= 1'b0;
      sensor    <= 1'b0;
    end else begin
      state     <= state_next;
      walk_wait <= wait_next;
      rearm     <= rearm_next;
      walk      <= (state_next == PENDING);
      car_req   <= car_req_next;
      sensor    <= car_req_next | db[1];
    end
  end

endmodule

// File: tb/tb_crossing_request_unit.sv
`timescale 1ns/1ps
// Scoreboard bench for crossing_request_unit: tasks queue per-edge expectations
// when driving stimulus and pop/compare them as each clock edge completes.
module tb_crossing_request_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       button_raw;
  logic       car_raw;
  logic       walk_light;
  logic [1:0] side_light;
  logic       walk;
  logic       sensor;
  logic [7:0] walk_wait;
  logic       walk3;
  logic       sensor3;
  logic [2:0] walk_wait3;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int    e;
    int    kind;
    int    val;
    string name;
  } exp_t;

  exp_t sb[$];

  localparam int K_WALK  = 0;
  localparam int K_SENS  = 1;
  localparam int K_WAIT  = 2;
  localparam int K_WAIT3 = 3;
  localparam int K_STATE = 4;
  localparam int K_WALK3 = 5;
  localparam int K_SENS3 = 6;

  always #5 clk = ~clk;

  crossing_request_unit #(.DEBOUNCE(4), .CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .button_raw (button_raw),
    .car_raw    (car_raw),
    .walk_light (walk_light),
    .side_light (side_light),
    .walk       (walk),
    .sensor     (sensor),
    .walk_wait  (walk_wait)
  );

  crossing_request_unit #(.DEBOUNCE(4), .CNT_W(3)) dut3 (
    .clk        (clk),
    .reset      (reset),
    .button_raw (button_raw),
    .car_raw    (car_raw),
    .walk_light (walk_light),
    .side_light (side_light),
    .walk       (walk3),
    .sensor     (sensor3),
    .walk_wait  (walk_wait3)
  );

  task automatic expect_at(input int e, input int kind, input int val, input string name);
    exp_t x;
    x.e    = e;
    x.kind = kind;
    x.val  = val;
    x.name = name;
    sb.push_back(x);
  endtask

  function automatic logic [31:0] obs_of(input int kind);
    case (kind)
      K_WALK:  return {31'b0, walk};
      K_SENS:  return {31'b0, sensor};
      K_WAIT:  return {24'b0, walk_wait};
      K_WAIT3: return {29'b0, walk_wait3};
      K_STATE: return {30'b0, dut.state};
      K_WALK3: return {31'b0, walk3};
      K_SENS3: return {31'b0, sensor3};
      default: return 'x;
    endcase
  endfunction

  task automatic flush_sb(input string tname);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL %s scoreboard: %0d expectations left, required 0", tname, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; button_raw = 1'b0; car_raw = 1'b0; walk_light = 1'b0; side_light = 2'b00;
    #2;
    vectors++;
    if (walk !== 1'b0) begin miscompares++; $display("FAIL reset_walk: got %b, expected 0", walk); end
    vectors++;
    if (sensor !== 1'b0) begin miscompares++; $display("FAIL reset_sensor: got %b, expected 0", sensor); end
    vectors++;
    if (walk_wait !== 8'd0) begin miscompares++; $display("FAIL reset_wait: got %0d, expected 0", walk_wait); end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_press_and_service;
    exp_t ex;
    expect_at(6,  K_WALK,  0,  "press_walk_e6");
    expect_at(7,  K_WALK,  1,  "press_walk_e7");
    expect_at(7,  K_WAIT,  0,  "press_wait_e7");
    expect_at(8,  K_WAIT,  1,  "press_wait_e8");
    expect_at(16, K_WALK,  1,  "pend_walk_e16");
    expect_at(16, K_WAIT,  9,  "pend_wait_e16");
    expect_at(17, K_WALK,  0,  "serve_walk_e17");
    expect_at(17, K_WAIT,  10, "serve_wait_e17");
    expect_at(21, K_STATE, 2,  "serve_state_e21");
    expect_at(21, K_WAIT,  10, "serve_wait_e21");
    expect_at(22, K_STATE, 0,  "idle_state_e22");
    expect_at(22, K_WAIT,  10, "idle_wait_e22");
    expect_at(30, K_WALK,  0,  "idle_walk_e30");
    expect_at(30, K_STATE, 0,  "idle_state_e30");
    for (int e = 1; e <= 30; e++) begin
      button_raw = (e <= 20);
      walk_light = (e >= 17 && e <= 21);
      @(posedge clk); #1;
      while (sb.size() > 0 && sb[0].e == e) begin
        ex = sb.pop_front();
        vectors++;
        if (obs_of(ex.kind) !== 32'(ex.val)) begin
          miscompares++;
          $display("FAIL %s: got %0d, expected %0d", ex.name, obs_of(ex.kind), ex.val);
        end
      end
    end
    flush_sb("press_and_service");
  endtask

  task automatic test_glitch;
    exp_t ex;
    expect_at(6,  K_WALK,  0, "glitch_walk_e6");
    expect_at(7,  K_WALK,  0, "glitch_walk_e7");
    expect_at(8,  K_WALK,  0, "glitch_walk_e8");
    expect_at(12, K_STATE, 0, "glitch_state_e12");
    for (int e = 1; e <= 12; e++) begin
      button_raw = (e <= 3);
      @(posedge clk); #1;
      while (sb.size() > 0 && sb[0].e == e) begin
        ex = sb.pop_front();
        vectors++;
        if (obs_of(ex.kind) !== 32'(ex.val)) begin
          miscompares++;
          $display("FAIL %s: got %0d, expected %0d", ex.name, obs_of(ex.kind), ex.val);
        end
      end
    end
    flush_sb("glitch");
  endtask

  task automatic test_rearm;
    exp_t ex;
    expect_at(10, K_WALK,  0, "rearm_walk_e10");
    expect_at(10, K_WAIT,  3, "rearm_wait_e10");
    expect_at(10, K_STATE, 2, "rearm_state_e10");
    expect_at(25, K_WALK,  0, "rearm_walk_e25");
    expect_at(25, K_WAIT,  3, "rearm_wait_e25");
    expect_at(26, K_WALK,  1, "rearm_walk_e26");
    expect_at(26, K_WAIT,  0, "rearm_wait_e26");
    expect_at(27, K_WAIT,  1, "rearm_wait_e27");
    expect_at(30, K_STATE, 0, "rearm_state_e30");
    expect_at(36, K_WALK,  0, "rearm_walk_e36");
    for (int e = 1; e <= 36; e++) begin
      button_raw = (e <= 8) || (e >= 16 && e <= 27);
      walk_light = (e >= 10 && e <= 25) || (e >= 28 && e <= 29);
      @(posedge clk); #1;
      while (sb.size() > 0 && sb[0].e == e) begin
        ex = sb.pop_front();
        vectors++;
        if (obs_of(ex.kind) !== 32'(ex.val)) begin
          miscompares++;
          $display("FAIL %s: got %0d, expected %0d", ex.name, obs_of(ex.kind), ex.val);
        end
      end
    end
    walk_light = 1'b0;
    flush_sb("rearm");
  endtask

  task automatic test_sensor;
    exp_t ex;
    expect_at(6,  K_SENS, 0, "sens_e6");
    expect_at(7,  K_SENS, 1, "sens_e7");
    expect_at(10, K_WALK, 0, "sens_walk_e10");
    expect_at(13, K_SENS, 1, "sens_held_e13");
    expect_at(20, K_SENS, 1, "sens_held_e20");
    expect_at(21, K_SENS, 0, "sens_green_e21");
    expect_at(24, K_SENS, 0, "sens_e24");
    expect_at(38, K_SENS, 1, "sens_cardb_e38");
    expect_at(42, K_SENS, 0, "sens_clear_wins_e42");
    expect_at(44, K_SENS, 0, "sens_e44");
    for (int e = 1; e <= 44; e++) begin
      car_raw    = (e <= 6) || (e >= 30 && e <= 35);
      side_light = ((e >= 21 && e <= 22) || e == 36) ? 2'b10 : 2'b00;
      @(posedge clk); #1;
      while (sb.size() > 0 && sb[0].e == e) begin
        ex = sb.pop_front();
        vectors++;
        if (obs_of(ex.kind) !== 32'(ex.val)) begin
          miscompares++;
          $display("FAIL %s: got %0d, expected %0d", ex.name, obs_of(ex.kind), ex.val);
        end
      end
    end
    side_light = 2'b00;
    flush_sb("sensor");
  endtask

  task automatic test_saturate_and_reset;
    exp_t ex;
    expect_at(7,  K_WALK,  1,  "sat_walk_e7");
    expect_at(13, K_WAIT3, 6,  "sat_wait3_e13");
    expect_at(14, K_WAIT3, 7,  "sat_wait3_e14");
    expect_at(19, K_WAIT,  12, "sat_wait_e19");
    expect_at(19, K_WAIT3, 7,  "sat_wait3_e19");
    expect_at(19, K_WALK3, 1,  "sat_walk3_e19");
    expect_at(20, K_SENS,  1,  "sat_sens_e20");
    expect_at(20, K_SENS3, 1,  "sat_sens3_e20");
    expect_at(20, K_WALK,  1,  "sat_walk_e20");
    for (int e = 1; e <= 20; e++) begin
      button_raw = 1'b1;
      car_raw    = 1'b1;
      @(posedge clk); #1;
      while (sb.size() > 0 && sb[0].e == e) begin
        ex = sb.pop_front();
        vectors++;
        if (obs_of(ex.kind) !== 32'(ex.val)) begin
          miscompares++;
          $display("FAIL %s: got %0d, expected %0d", ex.name, obs_of(ex.kind), ex.val);
        end
      end
    end
    flush_sb("saturate");
    #2 reset = 1'b0;
    #1;
    vectors++;
    if (walk !== 1'b0) begin miscompares++; $display("FAIL async_rst_walk: got %b, expected 0", walk); end
    vectors++;
    if (sensor !== 1'b0) begin miscompares++; $display("FAIL async_rst_sensor: got %b, expected 0", sensor); end
    vectors++;
    if (walk_wait !== 8'd0) begin miscompares++; $display("FAIL async_rst_wait: got %0d, expected 0", walk_wait); end
    vectors++;
    if (walk_wait3 !== 3'd0) begin miscompares++; $display("FAIL async_rst_wait3: got %0d, expected 0", walk_wait3); end
    car_raw = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    expect_at(6, K_WALK, 0, "held_walk_e6");
    expect_at(7, K_WALK, 1, "held_walk_e7");
    expect_at(8, K_WAIT, 1, "held_wait_e8");
    expect_at(8, K_SENS, 0, "held_sens_e8");
    for (int e = 1; e <= 8; e++) begin
      button_raw = 1'b1;
      @(posedge clk); #1;
      while (sb.size() > 0 && sb[0].e == e) begin
        ex = sb.pop_front();
        vectors++;
        if (obs_of(ex.kind) !== 32'(ex.val)) begin
          miscompares++;
          $display("FAIL %s: got %0d, expected %0d", ex.name, obs_of(ex.kind), ex.val);
        end
      end
    end
    flush_sb("held_through_reset");
  endtask

  initial begin
    test_reset();
    test_press_and_service();
    test_glitch();
    test_rearm();
    test_sensor();
    test_saturate_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
